keypad_scan: RTL and testbench
==============================

# keypad_scan

Matrix-keypad front end feeding the circle/sprite control stage. Drives a 5-row × 4-column keypad, synchronises and debounces the column returns, and encodes each new stable key press into a 5-bit code. Codes are queued in a small FIFO and presented as `keyCode`/`keyReady`. The downstream stage consumes them with a one-cycle active-low `rdn` pulse and detects new keys on the rising edge of `keyReady`.

## Interface
- `SCAN_DIV`, 1000: clock cycles per row slot; must be ≥ 4.
- `DEBOUNCE_FRAMES`, 4: consecutive identical frames needed to change the stable key; ≥ 1.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `REPEAT_FRAMES`, 64: auto-repeat period in frames; used only with `KEYPAD_REPEAT_EN`.

- `clk` in 1: system clock; all logic on posedge.
- `rstn` in 1: synchronous, active-low reset.
- `kb_row` out 5: row drive, one-hot-low; the active row is 0.
- `kb_col` in 4: column sense; active-low, externally pulled up, asynchronous.
- `keyCode` out 5: FIFO head code, `{row_idx[2:0], col_idx[1:0]}`, range 0..19.
- `keyReady` out 1: head valid.
- `rdn` in 1: active-low pop request from the consumer.
- `overflow` out 1: sticky flag; a code was dropped because the FIFO was full.
- `fifo_count` out 3: current FIFO occupancy.

## Operation
- **Input sync:** `kb_col` passes through a 2-flop synchroniser before use.
- **Row scan:** row index counts 0→4 and wraps. Each slot lasts `SCAN_DIV` cycles. The synchronised columns are sampled on the last cycle of the slot.
- **Frame:** one pass over 5 slots. At frame end the frame result is computed:
  - exactly one key pressed → that key's code;
  - zero keys, or more than one key → NONE (no code).
- **Debounce:**
  - If the frame result equals `cand`, `cnt` increments, saturating at `DEBOUNCE_FRAMES`.
  - Otherwise `cand` takes the frame result and `cnt` is set to 1.
  - When `cnt == DEBOUNCE_FRAMES` and `cand != stable`, `stable` takes `cand`.
  - If the new `stable` is a key, that code is pushed. A transition to NONE (release) pushes nothing.
- **FIFO:** circular buffer with read/write pointers and a count.
  - Push while full: the code is dropped, `overflow` is set to 1, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both take effect and the count is unchanged.
- **Pop:** a pop is accepted in a cycle where `rdn == 0`, `rdn` was 1 in the previous cycle, and `keyReady == 1`.
  - Falling edges of `rdn` while `keyReady == 0` are ignored.
  - Holding `rdn` low pops exactly once.
- **Ready gap:** after an accepted pop, `keyReady` is forced to 0 for exactly 2 cycles. It then reflects `fifo_count != 0`. This guarantees a rising edge for every queued code.
- **Output hold:** `keyCode` is the head entry whenever `keyReady == 1`, and holds its last value otherwise.

## Timing
- **Reset values** (while `rstn == 0` at a posedge):
  - `kb_row = 5'b11110`
  - `keyCode = 0`, `keyReady = 0`, `overflow = 0`, `fifo_count = 0`
  - scan counters, `cand`, `cnt`, `stable` (= NONE), FIFO pointers and the synchroniser are all cleared.
- **Mid-operation reset:** reset mid-scan or mid-pop discards all FIFO contents, and any in-progress debounce is lost.
- **Row advance:** `kb_row` changes on the cycle after a slot's sample cycle.
- **Push latency:** the push occurs on the frame-end cycle. `fifo_count` and `keyReady` update on the next posedge, so `keyReady` rises 1 cycle after the push when the FIFO was empty and no gap is active.
- **Minimum press-to-ready:** `DEBOUNCE_FRAMES` full frames plus up to 1 frame of alignment, plus 3 cycles (2 sync + 1 register).
- **Pop update:** `fifo_count` decrements on the posedge after the accepted pop cycle. The gap cycles follow that posedge.

## Configuration
- **`KEYPAD_REPEAT_EN` defined:**
  - While `stable` is a key and unchanged, a frame counter runs.
  - Every `REPEAT_FRAMES` frames the same code is pushed again, subject to the normal full/overflow rules.
  - The counter clears whenever `stable` changes.
- **Not defined:** no repeat logic is built. Exactly one push occurs per stable press.

## Test plan
Bench parameters for all scenarios: `SCAN_DIV=4`, `DEBOUNCE_FRAMES=2`, `FIFO_DEPTH=4`.
1. Drive `rstn=0` for 2 cycles, then release → `kb_row=11110`, `keyReady=0`, `fifo_count=0`. After 4 cycles `kb_row=11101`; rows wrap back to `11110` after 20 cycles.
2. Hold key row 2 / col 1 for 3 frames, then pulse `rdn` low for 1 cycle → `keyCode=5'h09`, `keyReady=1`, `fifo_count=1`. After the pulse, `keyReady=0` for 2 cycles and `fifo_count=0`.
3. Bounce col 3 on alternate frames, then hold it for 1 frame only → no push, `keyReady` stays 0.
4. Press 5 distinct keys with no pops (codes 0, 1, 4, 5, 8) → `fifo_count=4`, `overflow=1`. Popping with gaps yields 0, 1, 4, 5, each preceded by a `keyReady` rising edge.
5. Hold two keys in the same frame → treated as NONE, nothing pushed. Push and pop landing on the same cycle → `fifo_count` unchanged.
6. With `KEYPAD_REPEAT_EN` and `REPEAT_FRAMES=3`, hold code `0x0D` → pushes at debounce, then every 3 frames. Without the macro → exactly 1 push.

Source files
------------

// File: rtl/keypad_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scan : 5x4 keypad scanner, debouncer and key-code FIFO.           |
// | Optional auto-repeat built when KEYPAD_REPEAT_EN is defined. Rev 1.0     |
// +--------------------------------------------------------------------------+
module keypad_scan #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int REPEAT_FRAMES   = 64
) (
   input  logic       clk,
   input  logic       rstn,
   output logic [4:0] kb_row,
   input  logic [3:0] kb_col,
   output logic [4:0] keyCode,
   output logic       keyReady,
   input  logic       rdn,
   output logic       overflow,
   output logic [2:0] fifo_count
);
   localparam int c_DIV_W = $clog2(SCAN_DIV);
   localparam int c_CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_OCC_W = c_PTR_W + 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_DB       = c_CNT_W'(DEBOUNCE_FRAMES);
   localparam logic [c_OCC_W-1:0] c_FULL     = c_OCC_W'(FIFO_DEPTH);
   localparam logic [4:0]         c_NONE     = 5'd31;

   logic [3:0]         r_col_s1, r_col_s2;
   logic [c_DIV_W-1:0] r_div;
   logic [2:0]         r_row;
   logic [4:0]         r_kb_row;
   logic [1:0]         r_nkeys;
   logic [4:0]         r_fcode;
   logic [4:0]         r_cand, r_stable;
   logic [c_CNT_W-1:0] r_cnt;
   logic [4:0]         r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr, r_rd;
   logic [c_OCC_W-1:0] r_occ;
   logic               r_overflow, r_ready, r_gap, r_rdn_d;
   logic [4:0]         r_code;

   logic               w_sample, w_frame_end, w_change, w_push, w_push_db, w_push_rep;
   logic               w_full, w_pop, w_push_ok, w_ready_nx;
   logic [3:0]         w_hit;
   logic [2:0]         w_slot_cnt, w_sum, w_row_nx;
   logic [1:0]         w_slot_col, w_tot;
   logic [4:0]         w_fcode, w_result, w_cand_nx, w_push_code, w_head_nx;
   logic [c_CNT_W-1:0] w_cnt_nx;
   logic [c_PTR_W-1:0] w_rd_nx;
   logic [c_OCC_W-1:0] w_occ_nx;

   // Frame result: r_nkeys saturates at 2 so "more than one key" collapses to NONE
   always_comb begin
      w_sample    = (r_div == c_DIV_LAST);
      w_frame_end = w_sample && (r_row == 3'd4);
      w_row_nx    = (r_row == 3'd4) ? 3'd0 : r_row + 3'd1;
      w_hit       = ~r_col_s2;
      w_slot_cnt  = 3'(w_hit[0]) + 3'(w_hit[1]) + 3'(w_hit[2]) + 3'(w_hit[3]);
      w_slot_col  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_hit[i]) w_slot_col = 2'(i);
      end
      w_sum    = {1'b0, r_nkeys} + ((w_slot_cnt > 3'd1) ? 3'd2 : w_slot_cnt);
      w_tot    = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
      w_fcode  = (r_nkeys == 2'd0 && w_slot_cnt == 3'd1) ? {r_row, w_slot_col} : r_fcode;
      w_result = (w_tot == 2'd1) ? w_fcode : c_NONE;

      w_cand_nx = w_result;
      w_cnt_nx  = c_CNT_W'(1);
      if (w_result == r_cand) begin
         w_cand_nx = r_cand;
         w_cnt_nx  = (r_cnt == c_DB) ? c_DB : r_cnt + c_CNT_W'(1);
      end
      w_change  = w_frame_end && (w_cnt_nx == c_DB) && (w_cand_nx != r_stable);
      w_push_db = w_change && (w_cand_nx != c_NONE);
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int c_REP_W = $clog2(REPEAT_FRAMES + 1);
   localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_FRAMES - 1);
   logic [c_REP_W-1:0] r_rep;

   assign w_push_rep = w_frame_end && !w_change && (r_stable != c_NONE) && (r_rep == c_REP_LAST);

   always_ff @(posedge clk) begin
      if (!rstn || w_change || w_push_rep) begin
         r_rep <= '0;
      end else if (w_frame_end && r_stable != c_NONE) begin
         r_rep <= r_rep + c_REP_W'(1);
      end
   end
`else
   // REPEAT_FRAMES is meaningless in this build; the term is constant false
   assign w_push_rep = (REPEAT_FRAMES < 0);
`endif

   always_comb begin
      w_push      = w_push_db || w_push_rep;
      w_push_code = w_push_db ? w_cand_nx : r_stable;
      w_full      = (r_occ == c_FULL);
      w_pop       = !rdn && r_rdn_d && r_ready;
      w_push_ok   = w_push && !w_full;
      w_rd_nx     = w_pop ? r_rd + c_PTR_W'(1) : r_rd;
      case ({w_push_ok, w_pop})
         2'b10:   w_occ_nx = r_occ + c_OCC_W'(1);
         2'b01:   w_occ_nx = r_occ - c_OCC_W'(1);
         default: w_occ_nx = r_occ;
      endcase
      // Pushing into an empty (or just-emptied) FIFO bypasses the memory
      w_head_nx  = (w_push_ok && r_wr == w_rd_nx) ? w_push_code : r_mem[w_rd_nx];
      w_ready_nx = !w_pop && !r_gap && (w_occ_nx != '0);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_col_s1 <= 4'hF;
         r_col_s2 <= 4'hF;
         r_div    <= '0;
         r_row    <= 3'd0;
         r_kb_row <= 5'b11110;
         r_nkeys  <= 2'd0;
         r_fcode  <= 5'd0;
      end else begin
         r_col_s1 <= kb_col;
         r_col_s2 <= r_col_s1;
         if (w_sample) begin
            r_div    <= '0;
            r_row    <= w_row_nx;
            r_kb_row <= ~(5'b00001 << w_row_nx);
            r_nkeys  <= w_frame_end ? 2'd0 : w_tot;
            r_fcode  <= w_frame_end ? 5'd0 : w_fcode;
         end else begin
            r_div <= r_div + c_DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cand   <= c_NONE;
         r_cnt    <= '0;
         r_stable <= c_NONE;
      end else if (w_frame_end) begin
         r_cand <= w_cand_nx;
         r_cnt  <= w_cnt_nx;
         if (w_change) r_stable <= w_cand_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr] <= w_push_code;
   end

   // r_gap plus the pop cycle itself give the two forced-low keyReady cycles
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_occ      <= '0;
         r_overflow <= 1'b0;
         r_ready    <= 1'b0;
         r_gap      <= 1'b0;
         r_rdn_d    <= 1'b1;
         r_code     <= 5'd0;
      end else begin
         r_rdn_d <= rdn;
         if (w_push_ok) r_wr <= r_wr + c_PTR_W'(1);
         r_rd  <= w_rd_nx;
         r_occ <= w_occ_nx;
         if (w_push && w_full) r_overflow <= 1'b1;
         r_gap   <= w_pop;
         r_ready <= w_ready_nx;
         if (w_ready_nx) r_code <= w_head_nx;
      end
   end

   generate
      if (c_OCC_W >= 3) begin : g_occ_wide
         assign fifo_count = r_occ[2:0];
      end else begin : g_occ_narrow
         assign fifo_count = {{(3 - c_OCC_W){1'b0}}, r_occ};
      end
   endgenerate

   assign kb_row   = r_kb_row;
   assign keyCode  = r_code;
   assign keyReady = r_ready;
   assign overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// tb_keypad_scan: table vectors, hand sequences and a randomized frame-level
// reference model for keypad_scan (SCAN_DIV=4, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4).
module tb_keypad_scan;
   localparam int SCAN_DIV = 4;
   localparam int DB       = 2;
   localparam int DEPTH    = 4;
   localparam int REP      = 3;
   localparam int FRAME    = 5 * SCAN_DIV;
   localparam logic [4:0] NONE = 5'd31;
`ifdef KEYPAD_REPEAT_EN
   localparam int REP_EXP = 4;
`else
   localparam int REP_EXP = 2;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rdn = 1'b1;
   logic [4:0] kb_row, keyCode;
   logic [3:0] kb_col;
   logic       keyReady, overflow;
   logic [2:0] fifo_count;
   logic [4:0] key_a = NONE, key_b = NONE;
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DB), .FIFO_DEPTH(DEPTH),
                 .REPEAT_FRAMES(REP)) dut (
      .clk(clk), .rstn(rstn), .kb_row(kb_row), .kb_col(kb_col), .keyCode(keyCode),
      .keyReady(keyReady), .rdn(rdn), .overflow(overflow), .fifo_count(fifo_count));

   // Keypad: a held key pulls its column low while its row is driven low
   always_comb begin
      kb_col = 4'hF;
      for (int r = 0; r < 5; r++) begin
         if (!kb_row[r]) begin
            if (key_a != NONE && int'(key_a[4:2]) == r) kb_col[key_a[1:0]] = 1'b0;
            if (key_b != NONE && int'(key_b[4:2]) == r) kb_col[key_b[1:0]] = 1'b0;
         end
      end
   end

   // Frame-level reference model
   logic [4:0] mq[$];
   logic [4:0] hist[$];
   logic [4:0] m_stable = NONE;
   bit         m_ovf = 1'b0;
   int         m_since = 0;

   function automatic logic [4:0] frame_result(input logic [4:0] a, input logic [4:0] b);
      if (a == NONE) return b;
      if (b == NONE || a == b) return a;
      return NONE;
   endfunction

   task automatic model_reset();
      mq.delete(); hist.delete();
      m_stable = NONE; m_ovf = 1'b0; m_since = 0;
   endtask

   task automatic model_push(input logic [4:0] c);
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back(c);
   endtask

   task automatic model_frame(input logic [4:0] res);
      bit settled;
      hist.push_back(res);
      if (hist.size() > DB) void'(hist.pop_front());
      settled = (hist.size() == DB);
      foreach (hist[i]) if (hist[i] != res) settled = 1'b0;
      if (settled && res != m_stable) begin
         m_stable = res;
         m_since  = 0;
         if (res != NONE) model_push(res);
      end else begin
         m_since++;
`ifdef KEYPAD_REPEAT_EN
         if (m_stable != NONE && m_since % REP == 0) model_push(m_stable);
`endif
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; rdn = 1'b1; key_a = NONE; key_b = NONE;
      step(); step();
      rstn = 1'b1;
      model_reset();
   endtask

   task automatic frame_check(input string tag);
      chk({tag, "_count"}, int'(fifo_count), mq.size());
      chk({tag, "_ready"}, int'(keyReady), int'(mq.size() != 0));
      chk({tag, "_ovf"}, int'(overflow), int'(m_ovf));
      if (mq.size() != 0) chk({tag, "_head"}, int'(keyCode), int'(mq[0]));
   endtask

   // One frame from its cycle 0; optional pop with rdn held low for 'hold' cycles
   task automatic run_frame(input bit do_pop, input int hold, input logic [4:0] a,
                            input logic [4:0] b);
      chk("frame_align_row", int'(kb_row), 5'b11110);
      key_a = a; key_b = b;
      if (do_pop) begin
         chk("pop_ready", int'(keyReady), 1);
         if (mq.size() != 0) begin
            chk("pop_code", int'(keyCode), int'(mq[0]));
            void'(mq.pop_front());
         end
         rdn = 1'b0;
         for (int i = 1; i <= FRAME; i++) begin
            step();
            if (i == hold) rdn = 1'b1;
            if (i <= 2) chk("pop_gap", int'(keyReady), 0);
         end
         rdn = 1'b1;
      end else begin
         for (int i = 0; i < FRAME; i++) step();
      end
      model_frame(frame_result(a, b));
   endtask

   typedef struct {
      bit         pop;
      logic [4:0] a;
      logic [4:0] b;
      int         frames;
      int         cnt;
      bit         ovf;
      logic [4:0] head;
   } vec_t;
   vec_t tbl [21];

   initial begin
      tbl[0]  = '{1'b0, 5'h09, NONE,  3, 1, 1'b0, 5'h09};
      tbl[1]  = '{1'b1, NONE,  NONE,  2, 0, 1'b0, 5'h00};
      tbl[2]  = '{1'b0, 5'h03, NONE,  1, 0, 1'b0, 5'h00};
      tbl[3]  = '{1'b0, NONE,  NONE,  1, 0, 1'b0, 5'h00};
      tbl[4]  = '{1'b0, 5'h03, NONE,  1, 0, 1'b0, 5'h00};
      tbl[5]  = '{1'b0, NONE,  NONE,  1, 0, 1'b0, 5'h00};
      tbl[6]  = '{1'b0, 5'h03, NONE,  1, 0, 1'b0, 5'h00};
      tbl[7]  = '{1'b0, NONE,  NONE,  1, 0, 1'b0, 5'h00};
      tbl[8]  = '{1'b0, 5'h00, NONE,  2, 1, 1'b0, 5'h00};
      tbl[9]  = '{1'b0, 5'h01, NONE,  2, 2, 1'b0, 5'h00};
      tbl[10] = '{1'b0, 5'h04, NONE,  2, 3, 1'b0, 5'h00};
      tbl[11] = '{1'b0, 5'h05, NONE,  2, 4, 1'b0, 5'h00};
      tbl[12] = '{1'b0, 5'h08, NONE,  2, 4, 1'b1, 5'h00};
      tbl[13] = '{1'b0, NONE,  NONE,  2, 4, 1'b1, 5'h00};
      tbl[14] = '{1'b1, NONE,  NONE,  1, 3, 1'b1, 5'h01};
      tbl[15] = '{1'b1, NONE,  NONE,  1, 2, 1'b1, 5'h04};
      tbl[16] = '{1'b1, NONE,  NONE,  1, 1, 1'b1, 5'h05};
      tbl[17] = '{1'b1, NONE,  NONE,  1, 0, 1'b1, 5'h00};
      tbl[18] = '{1'b0, 5'h02, 5'h06, 3, 0, 1'b1, 5'h00};
      tbl[19] = '{1'b0, 5'h00, 5'h01, 3, 0, 1'b1, 5'h00};
      tbl[20] = '{1'b0, NONE,  NONE,  1, 0, 1'b1, 5'h00};

      // Reset values and row scan timing
      do_reset();
      chk("rst_row", int'(kb_row), 5'b11110);
      chk("rst_ready", int'(keyReady), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_code", int'(keyCode), 0);
      step(); step(); step();
      chk("row0_held", int'(kb_row), 5'b11110);
      step();
      chk("row1", int'(kb_row), 5'b11101);
      for (int i = 5; i <= FRAME; i++) step();
      chk("row_wrap", int'(kb_row), 5'b11110);
      model_frame(NONE);

      foreach (tbl[i]) begin
         for (int f = 0; f < tbl[i].frames; f++)
            run_frame(tbl[i].pop && f == 0, 1, tbl[i].a, tbl[i].b);
         chk($sformatf("tbl%0d_count", i), int'(fifo_count), tbl[i].cnt);
         chk($sformatf("tbl%0d_ready", i), int'(keyReady), int'(tbl[i].cnt != 0));
         chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
         if (tbl[i].cnt != 0) chk($sformatf("tbl%0d_head", i), int'(keyCode), int'(tbl[i].head));
      end

      // Reset in the middle of a scan and a pop
      run_frame(1'b0, 1, 5'h13, NONE);
      run_frame(1'b0, 1, 5'h13, NONE);
      chk("mid_pre_count", int'(fifo_count), 1);
      rdn = 1'b0;
      step(); step(); step();
      do_reset();
      chk("mid_count", int'(fifo_count), 0);
      chk("mid_ready", int'(keyReady), 0);
      chk("mid_ovf", int'(overflow), 0);
      chk("mid_code", int'(keyCode), 0);
      chk("mid_row", int'(kb_row), 5'b11110);

      // Push and pop landing on the same frame-end cycle
      run_frame(1'b0, 1, 5'h0A, NONE);
      run_frame(1'b0, 1, 5'h0A, NONE);
      chk("pp_pre_count", int'(fifo_count), 1);
      run_frame(1'b0, 1, NONE, NONE);
      run_frame(1'b0, 1, 5'h0C, NONE);
      key_a = 5'h0C; key_b = NONE;
      for (int i = 0; i < FRAME - 1; i++) step();
      chk("pp_edge_count", int'(fifo_count), 1);
      chk("pp_edge_ready", int'(keyReady), 1);
      chk("pp_edge_code", int'(keyCode), 5'h0A);
      rdn = 1'b0;
      step();
      rdn = 1'b1;
      chk("pp_count", int'(fifo_count), 1);
      chk("pp_gap1", int'(keyReady), 0);
      model_frame(5'h0C);
      void'(mq.pop_front());
      step();
      chk("pp_gap2", int'(keyReady), 0);
      step();
      chk("pp_ready", int'(keyReady), 1);
      chk("pp_code", int'(keyCode), 5'h0C);
      for (int i = 3; i <= FRAME; i++) step();
      model_frame(5'h0C);
      frame_check("pp");

      // Long hold: one push, or periodic pushes with auto-repeat
      for (int f = 0; f < 10; f++) begin
         run_frame(1'b0, 1, 5'h0D, NONE);
         frame_check("rep");
      end
      chk("rep_total", int'(fifo_count), REP_EXP);
      for (int f = 0; f < 8 && mq.size() != 0; f++) begin
         run_frame(1'b1, 1, NONE, NONE);
         frame_check("drain");
      end

      // Randomized key activity and pops against the model
      do_reset();
      begin
         int         hold_left;
         logic [4:0] ca, cb;
         int         sel, n;
         bit         pop;
         hold_left = 0; ca = NONE; cb = NONE;
         for (int f = 0; f < 90; f++) begin
            if (hold_left == 0) begin
               sel = int'($urandom % 6);
               n   = int'($urandom % 20);
               if (sel < 2) begin
                  ca = NONE; cb = NONE;
               end else if (sel == 2) begin
                  ca = 5'(n);
                  cb = 5'((n + 1 + int'($urandom % 19)) % 20);
               end else begin
                  ca = 5'(n); cb = NONE;
               end
               hold_left = int'($urandom_range(1, 3));
            end
            pop = (mq.size() != 0) && ($urandom % 3 == 0);
            run_frame(pop, int'($urandom_range(1, 4)), ca, cb);
            hold_left--;
            frame_check("rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
